// File: rtl/pipe_pkg.sv
// Shared state encoding and default widths for the ID/EX skid stage.
package pipe_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int RA_W_DEF    = 5;
    localparam int ALUOP_W_DEF = 4;
    localparam int CNT_W_DEF   = 16;

    // EMPTY: nothing held; BUSY: main holds a bundle; FULL: main and skid both hold bundles.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [ALUOP_W_DEF-1:0] aluop;
        logic                   alusrc;
        logic                   regwrite;
        logic                   memtoreg;
        logic                   memwrite;
        logic                   memread;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic [RA_W_DEF-1:0] ars1;
        logic [RA_W_DEF-1:0] ars2;
        logic [RA_W_DEF-1:0] ard;
        logic [XLEN_DEF-1:0] rs1;
        logic [XLEN_DEF-1:0] rs2;
        logic [XLEN_DEF-1:0] imm;
    } id_ex_data_t;

    typedef struct packed {
        id_ex_ctrl_t ctrl;
        id_ex_data_t data;
    } id_ex_t;

endpackage

// File: rtl/pipe_skid_ctl.sv
// Skid-buffer FSM: decides where each bundle goes, owns IN_READY and the stall counter.
module pipe_skid_ctl
    import pipe_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic             in_ready,
    output logic             out_valid,
    output logic             load_main,
    output logic             load_skid,
    output logic             move_skid,
    output logic             clear_main,
    output logic             clear_skid,
    output logic [CNT_W-1:0] stall_cnt
);

    skid_state_t state, next_state;
    logic        accept, consume;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;
    assign out_valid = (state != EMPTY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (accept) next_state = BUSY;
                BUSY: begin
                    if (accept && !consume)      next_state = FULL;
                    else if (!accept && consume) next_state = EMPTY;
                end
                FULL:    if (consume) next_state = BUSY;
                default: next_state = EMPTY;
            endcase
        end
    end

    // A vacated register is always cleared so the outputs read 0 whenever OUT_VALID is low.
    always_comb begin
        load_main  = 1'b0;
        load_skid  = 1'b0;
        move_skid  = 1'b0;
        clear_main = 1'b0;
        clear_skid = 1'b0;
        if (flush) begin
            clear_main = 1'b1;
            clear_skid = 1'b1;
        end else begin
            case (state)
                EMPTY: load_main = accept;
                BUSY: begin
                    load_main  = accept & consume;
                    load_skid  = accept & ~consume;
                    clear_main = ~accept & consume;
                end
                FULL:    move_skid = consume;
                default: begin
                    clear_main = 1'b1;
                    clear_skid = 1'b1;
                end
            endcase
        end
    end

    // Registered ready: depends only on next state, never combinationally on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) in_ready <= 1'b0;
        else     in_ready <= (next_state != FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         stall_cnt <= '0;
        else if (out_valid && !out_ready) stall_cnt <= sat_inc(stall_cnt);
    end

endmodule

// File: rtl/pipe_id_ex_skid.sv
// ID/EX pipeline stage with valid/ready handshake, 2-entry skid buffer, flush and stall counter.
module pipe_id_ex_skid
    import pipe_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RA_W    = RA_W_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic               FLUSH,
    input  logic [ALUOP_W-1:0] ALUOP_IN,
    input  logic               ALUSRC_IN,
    input  logic               REGWRITE_IN,
    input  logic               MEMTOREG_IN,
    input  logic               MEMWRITE_IN,
    input  logic               MEMREAD_IN,
    input  logic [RA_W-1:0]    ARS1_IN,
    input  logic [RA_W-1:0]    ARS2_IN,
    input  logic [RA_W-1:0]    ARD_IN,
    input  logic [XLEN-1:0]    RS1_IN,
    input  logic [XLEN-1:0]    RS2_IN,
    input  logic [XLEN-1:0]    IMMEDIATE_IN,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [ALUOP_W-1:0] ALUOP_OUT,
    output logic               ALUSRC_OUT,
    output logic               REGWRITE_OUT,
    output logic               MEMTOREG_OUT,
    output logic               MEMWRITE_OUT,
    output logic               MEMREAD_OUT,
    output logic [RA_W-1:0]    ARS1_OUT,
    output logic [RA_W-1:0]    ARS2_OUT,
    output logic [RA_W-1:0]    ARD_OUT,
    output logic [XLEN-1:0]    RS1_OUT,
    output logic [XLEN-1:0]    RS2_OUT,
    output logic [XLEN-1:0]    IMMEDIATE_OUT,
    output logic [CNT_W-1:0]   STALL_CNT
);

    // Same layout as the package bundle types, but sized by this instance's parameters.
    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               alusrc;
        logic               regwrite;
        logic               memtoreg;
        logic               memwrite;
        logic               memread;
    } ctrl_t;

    typedef struct packed {
        logic [RA_W-1:0] ars1;
        logic [RA_W-1:0] ars2;
        logic [RA_W-1:0] ard;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
    } data_t;

    typedef struct packed {
        ctrl_t ctrl;
        data_t data;
    } bundle_t;

    bundle_t in_p0, main_p1, skid_p1;
    logic    vld_p1;
    logic    load_main, load_skid, move_skid, clear_main, clear_skid;

    assign in_p0 = {ALUOP_IN, ALUSRC_IN, REGWRITE_IN, MEMTOREG_IN, MEMWRITE_IN, MEMREAD_IN,
                    ARS1_IN, ARS2_IN, ARD_IN, RS1_IN, RS2_IN, IMMEDIATE_IN};

    pipe_skid_ctl #(
        .CNT_W (CNT_W)
    ) u_ctl (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (IN_VALID),
        .out_ready  (OUT_READY),
        .flush      (FLUSH),
        .in_ready   (IN_READY),
        .out_valid  (vld_p1),
        .load_main  (load_main),
        .load_skid  (load_skid),
        .move_skid  (move_skid),
        .clear_main (clear_main),
        .clear_skid (clear_skid),
        .stall_cnt  (STALL_CNT)
    );

    // ---- stage p1: main (visible to EX) and skid (overflow) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            main_p1 <= '0;
        else if (clear_main) main_p1 <= '0;
        else if (load_main)  main_p1 <= in_p0;
        else if (move_skid)  main_p1 <= skid_p1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         skid_p1 <= '0;
        else if (clear_skid || move_skid) skid_p1 <= '0;
        else if (load_skid)               skid_p1 <= in_p0;
    end

    assign OUT_VALID = vld_p1;
    assign {ALUOP_OUT, ALUSRC_OUT, REGWRITE_OUT, MEMTOREG_OUT, MEMWRITE_OUT, MEMREAD_OUT,
            ARS1_OUT, ARS2_OUT, ARD_OUT, RS1_OUT, RS2_OUT, IMMEDIATE_OUT} = main_p1;

endmodule

// File: tb/tb_pipe_id_ex_skid.sv
// Directed plus randomized bench for pipe_id_ex_skid against a queue-based reference model.
module tb_pipe_id_ex_skid;

    typedef logic [119:0] bundle_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, IN_VALID, FLUSH, OUT_READY;
    bundle_t     in_b, out_b, out_b2;
    logic [3:0]  ALUOP_IN;
    logic        ALUSRC_IN, REGWRITE_IN, MEMTOREG_IN, MEMWRITE_IN, MEMREAD_IN;
    logic [4:0]  ARS1_IN, ARS2_IN, ARD_IN;
    logic [31:0] RS1_IN, RS2_IN, IMMEDIATE_IN;
    logic        IN_READY, OUT_VALID, IN_READY2, OUT_VALID2;
    logic [3:0]  ALUOP_OUT, ALUOP_OUT2;
    logic        ALUSRC_OUT, REGWRITE_OUT, MEMTOREG_OUT, MEMWRITE_OUT, MEMREAD_OUT;
    logic        ALUSRC_OUT2, REGWRITE_OUT2, MEMTOREG_OUT2, MEMWRITE_OUT2, MEMREAD_OUT2;
    logic [4:0]  ARS1_OUT, ARS2_OUT, ARD_OUT, ARS1_OUT2, ARS2_OUT2, ARD_OUT2;
    logic [31:0] RS1_OUT, RS2_OUT, IMMEDIATE_OUT, RS1_OUT2, RS2_OUT2, IMMEDIATE_OUT2;
    logic [15:0] STALL_CNT;
    logic [1:0]  STALL_CNT2;

    assign {ALUOP_IN, ALUSRC_IN, REGWRITE_IN, MEMTOREG_IN, MEMWRITE_IN, MEMREAD_IN,
            ARS1_IN, ARS2_IN, ARD_IN, RS1_IN, RS2_IN, IMMEDIATE_IN} = in_b;
    assign out_b  = {ALUOP_OUT, ALUSRC_OUT, REGWRITE_OUT, MEMTOREG_OUT, MEMWRITE_OUT, MEMREAD_OUT,
                     ARS1_OUT, ARS2_OUT, ARD_OUT, RS1_OUT, RS2_OUT, IMMEDIATE_OUT};
    assign out_b2 = {ALUOP_OUT2, ALUSRC_OUT2, REGWRITE_OUT2, MEMTOREG_OUT2, MEMWRITE_OUT2, MEMREAD_OUT2,
                     ARS1_OUT2, ARS2_OUT2, ARD_OUT2, RS1_OUT2, RS2_OUT2, IMMEDIATE_OUT2};

    pipe_id_ex_skid dut (
        .clk(clk), .rst(rst), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .FLUSH(FLUSH),
        .ALUOP_IN(ALUOP_IN), .ALUSRC_IN(ALUSRC_IN), .REGWRITE_IN(REGWRITE_IN),
        .MEMTOREG_IN(MEMTOREG_IN), .MEMWRITE_IN(MEMWRITE_IN), .MEMREAD_IN(MEMREAD_IN),
        .ARS1_IN(ARS1_IN), .ARS2_IN(ARS2_IN), .ARD_IN(ARD_IN),
        .RS1_IN(RS1_IN), .RS2_IN(RS2_IN), .IMMEDIATE_IN(IMMEDIATE_IN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .ALUOP_OUT(ALUOP_OUT), .ALUSRC_OUT(ALUSRC_OUT), .REGWRITE_OUT(REGWRITE_OUT),
        .MEMTOREG_OUT(MEMTOREG_OUT), .MEMWRITE_OUT(MEMWRITE_OUT), .MEMREAD_OUT(MEMREAD_OUT),
        .ARS1_OUT(ARS1_OUT), .ARS2_OUT(ARS2_OUT), .ARD_OUT(ARD_OUT),
        .RS1_OUT(RS1_OUT), .RS2_OUT(RS2_OUT), .IMMEDIATE_OUT(IMMEDIATE_OUT),
        .STALL_CNT(STALL_CNT)
    );

    pipe_id_ex_skid #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .IN_VALID(IN_VALID), .IN_READY(IN_READY2), .FLUSH(FLUSH),
        .ALUOP_IN(ALUOP_IN), .ALUSRC_IN(ALUSRC_IN), .REGWRITE_IN(REGWRITE_IN),
        .MEMTOREG_IN(MEMTOREG_IN), .MEMWRITE_IN(MEMWRITE_IN), .MEMREAD_IN(MEMREAD_IN),
        .ARS1_IN(ARS1_IN), .ARS2_IN(ARS2_IN), .ARD_IN(ARD_IN),
        .RS1_IN(RS1_IN), .RS2_IN(RS2_IN), .IMMEDIATE_IN(IMMEDIATE_IN),
        .OUT_VALID(OUT_VALID2), .OUT_READY(OUT_READY),
        .ALUOP_OUT(ALUOP_OUT2), .ALUSRC_OUT(ALUSRC_OUT2), .REGWRITE_OUT(REGWRITE_OUT2),
        .MEMTOREG_OUT(MEMTOREG_OUT2), .MEMWRITE_OUT(MEMWRITE_OUT2), .MEMREAD_OUT(MEMREAD_OUT2),
        .ARS1_OUT(ARS1_OUT2), .ARS2_OUT(ARS2_OUT2), .ARD_OUT(ARD_OUT2),
        .RS1_OUT(RS1_OUT2), .RS2_OUT(RS2_OUT2), .IMMEDIATE_OUT(IMMEDIATE_OUT2),
        .STALL_CNT(STALL_CNT2)
    );

    // Reference model: a FIFO of held bundles, a ready flag and an unbounded stall tally.
    bundle_t     q[$];
    logic        m_rdy;
    int unsigned m_stall;
    int          tests = 0;
    int          fails = 0;

    function automatic bundle_t mk(input logic [3:0] aluop, input logic [4:0] ctrl,
                                   input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                                   input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
        return {aluop, ctrl, a1, a2, ad, r1, r2, im};
    endfunction

    function automatic bundle_t rnd_bundle();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[119:0];
    endfunction

    function automatic logic [127:0] sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? 128'(mx) : 128'(v);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        bundle_t exp_b;
        exp_b = (q.size() > 0) ? q[0] : '0;
        chk("out_valid", OUT_VALID, q.size() > 0);
        chk("out_bundle", out_b, exp_b);
        chk("in_ready", IN_READY, m_rdy);
        chk("stall_cnt", STALL_CNT, sat(m_stall, 65535));
        chk("sat_out_valid", OUT_VALID2, q.size() > 0);
        chk("sat_out_bundle", out_b2, exp_b);
        chk("sat_stall_cnt", STALL_CNT2, sat(m_stall, 3));
    endtask

    // One clock: model evaluates handshakes with the pre-edge view, then compares after the edge.
    task automatic step();
        logic accept, consume;
        accept  = IN_VALID && m_rdy;
        consume = (q.size() > 0) && OUT_READY;
        if (q.size() > 0 && !OUT_READY) m_stall++;
        @(posedge clk);
        #1;
        if (FLUSH) begin
            q.delete();
            m_rdy = 1'b1;
        end else begin
            if (consume) void'(q.pop_front());
            if (accept)  q.push_back(in_b);
            m_rdy = (q.size() < 2);
        end
        check_model();
    endtask

    task automatic model_reset();
        q.delete();
        m_rdy   = 1'b0;
        m_stall = 0;
    endtask

    bundle_t a, b, c, d;

    initial begin
        a = mk(4'hA, 5'b00000, 5'd1, 5'd2, 5'd3, 32'hAAAAAAAA, 32'h0, 32'h12345678);
        b = mk(4'h3, 5'b11001, 5'd4, 5'd5, 5'd6, 32'hBBBB0001, 32'hCAFEF00D, 32'hFFFFFFFF);
        c = mk(4'h7, 5'b01110, 5'd7, 5'd8, 5'd9, 32'hC0C0C0C0, 32'h00000001, 32'h80000000);
        d = mk(4'h5, 5'b01010, 5'd10, 5'd11, 5'd12, 32'hDDDDDDDD, 32'h0BADBEEF, 32'h00000004);
        rst = 1'b1; IN_VALID = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b0; in_b = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", OUT_VALID, 1'b0);
        chk("rst_out_bundle", out_b, '0);
        chk("rst_in_ready", IN_READY, 1'b0);
        chk("rst_stall_cnt", STALL_CNT, '0);

        // Release reset; IN_READY must wait one edge before rising.
        rst = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b1; in_b = a;
        chk("post_rst_not_ready", IN_READY, 1'b0);
        step();
        chk("ready_after_edge", IN_READY, 1'b1);
        chk("not_yet_valid", OUT_VALID, 1'b0);
        step();
        chk("first_valid", OUT_VALID, 1'b1);
        chk("first_aluop", ALUOP_OUT, 4'hA);
        chk("first_rs1", RS1_OUT, 32'hAAAAAAAA);
        chk("first_imm", IMMEDIATE_OUT, 32'h12345678);

        // Streaming A then B, C with EX always ready.
        in_b = b; step();
        chk("stream_b", out_b, b);
        in_b = c; step();
        chk("stream_c", out_b, c);
        chk("stream_ready", IN_READY, 1'b1);
        IN_VALID = 1'b0; step();
        chk("stream_drained", OUT_VALID, 1'b0);
        chk("stream_no_stall", STALL_CNT, 16'd0);

        // Back-pressure fills main then skid.
        OUT_READY = 1'b0; IN_VALID = 1'b1; in_b = a; step();
        in_b = b; step();
        chk("bp_full_ready", IN_READY, 1'b0);
        chk("bp_hold_a", out_b, a);
        IN_VALID = 1'b0; in_b = c;
        step(); step();
        chk("bp_stall3", STALL_CNT, 16'd3);
        OUT_READY = 1'b1;
        chk("bp_yield_a", out_b, a);
        step();
        chk("bp_yield_b", out_b, b);
        chk("bp_ready_back", IN_READY, 1'b1);
        step();
        chk("bp_empty", OUT_VALID, 1'b0);

        // Flush while FULL with C presented: C must vanish, counter keeps counting.
        OUT_READY = 1'b0; IN_VALID = 1'b1; in_b = a; step();
        in_b = b; step();
        IN_VALID = 1'b0; step(); step();
        IN_VALID = 1'b1; in_b = c; FLUSH = 1'b1; step();
        FLUSH = 1'b0; IN_VALID = 1'b0;
        chk("flush_valid", OUT_VALID, 1'b0);
        chk("flush_regwrite", REGWRITE_OUT, 1'b0);
        chk("flush_memwrite", MEMWRITE_OUT, 1'b0);
        chk("flush_bundle", out_b, '0);
        chk("flush_ready", IN_READY, 1'b1);
        chk("flush_keeps_cnt", STALL_CNT, 16'd7);
        chk("cnt_saturated", STALL_CNT2, 2'd3);
        OUT_READY = 1'b1;
        repeat (3) step();
        chk("c_never_emitted", OUT_VALID, 1'b0);

        // Asynchronous reset mid-cycle while BUSY with a store in main.
        OUT_READY = 1'b0; IN_VALID = 1'b1; in_b = d; step();
        IN_VALID = 1'b0;
        chk("busy_memwrite", MEMWRITE_OUT, 1'b1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_valid", OUT_VALID, 1'b0);
        chk("arst_bundle", out_b, '0);
        chk("arst_memwrite", MEMWRITE_OUT, 1'b0);
        chk("arst_stall_cnt", STALL_CNT, 16'd0);
        chk("arst_sat_cnt", STALL_CNT2, 2'd0);
        #1 rst = 1'b0;
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            IN_VALID  = 1'($urandom_range(0, 1));
            OUT_READY = ($urandom_range(0, 3) != 0);
            FLUSH     = ($urandom_range(0, 24) == 0);
            in_b      = rnd_bundle();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
